// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-and-add multiplier: one partial-product step per cycle,
// full 2N-bit product after N iterations, start/busy/done handshake.
module seq_multiplier #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] product_low,
  output logic [N-1:0] product_high
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       m_q, m_d;
  logic [2*N-1:0]     p_q, p_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       prod_lo_q, prod_lo_d;
  logic [N-1:0]       prod_hi_q, prod_hi_d;
  logic [N-1:0]       addend;
  logic [N:0]         sum;

  // Upper half plus (optionally) the multiplicand; the extra bit is the true carry-out
  // and is shifted back into the partial product so no carry is lost.
  always_comb begin
    addend = p_q[0] ? m_q : '0;
    sum    = {1'b0, p_q[2*N-1:N]} + {1'b0, addend};
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    prod_lo_d = prod_lo_q;
    prod_hi_d = prod_hi_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          p_d     = {{N{1'b0}}, b};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d = {sum, p_q[N-1:1]};
        if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          prod_hi_d = p_d[2*N-1:N];
          prod_lo_d = p_d[N-1:0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      m_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      prod_lo_q <= prod_lo_d;
      prod_hi_q <= prod_hi_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign product_low  = prod_lo_q;
  assign product_high = prod_hi_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed and random operations on N=64 and N=8 instances,
// checked against plain wide-integer multiplication.
module tb_seq_multiplier;

  logic        clk;
  logic        rst64, start64, busy64, done64;
  logic [63:0] a64, b64, pl64, ph64;
  logic        rst8, start8, busy8, done8;
  logic [7:0]  a8, b8, pl8, ph8;

  int vectors;
  int miscompares;

  seq_multiplier #(.N(64)) dut64 (
    .clk(clk), .reset(rst64), .start(start64), .a(a64), .b(b64),
    .busy(busy64), .done(done64), .product_low(pl64), .product_high(ph64)
  );

  seq_multiplier #(.N(8)) dut8 (
    .clk(clk), .reset(rst8), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product_low(pl8), .product_high(ph8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel8, input logic s, input logic [63:0] av, input logic [63:0] bv);
    if (sel8) begin
      start8 = s; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      start64 = s; a64 = av; b64 = bv;
    end
  endtask

  function automatic logic [127:0] prod(input bit sel8);
    return sel8 ? {112'b0, ph8, pl8} : {ph64, pl64};
  endfunction

  function automatic logic get_busy(input bit sel8);
    return sel8 ? busy8 : busy64;
  endfunction

  function automatic logic get_done(input bit sel8);
    return sel8 ? done8 : done64;
  endfunction

  // One complete operation; optional ignored start pulses during RUN and DONE.
  task automatic run_op(input bit sel8, input logic [63:0] av, input logic [63:0] bv,
                        input int glitch_cyc, input bit glitch_done, input string tag);
    logic [127:0] exp;
    logic [127:0] prev;
    int w, cyc, busy_cnt;
    bit seen;
    w    = sel8 ? 8 : 64;
    exp  = sel8 ? ({120'b0, av[7:0]} * {120'b0, bv[7:0]}) : ({64'b0, av} * {64'b0, bv});
    prev = prod(sel8);
    drive(sel8, 1'b1, av, bv);
    @(posedge clk); #1;
    drive(sel8, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
    busy_cnt = get_busy(sel8) ? 1 : 0;
    cyc  = 0;
    seen = 0;
    while (cyc < 300 && !seen) begin
      if (glitch_cyc != 0 && cyc + 1 == glitch_cyc) drive(sel8, 1'b1, 64'd9, 64'd9);
      else drive(sel8, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
      @(posedge clk); #1;
      cyc++;
      if (get_busy(sel8)) busy_cnt++;
      if (get_done(sel8)) seen = 1;
      else if (cyc == w / 2) chk({tag, " hold_mid_run"}, prod(sel8), prev);
    end
    chk({tag, " latency"}, 128'(cyc), 128'(w));
    chk({tag, " product"}, prod(sel8), exp);
    chk({tag, " busy_cycles"}, 128'(busy_cnt), 128'(w + 1));
    if (glitch_done) drive(sel8, 1'b1, 64'd9, 64'd9);
    @(posedge clk); #1;
    drive(sel8, 1'b0, 64'd0, 64'd0);
    chk({tag, " done_drop"}, {126'b0, get_done(sel8), get_busy(sel8)}, 128'd0);
    if (glitch_done) begin
      repeat (3) @(posedge clk);
      #1;
      chk({tag, " no_queued_start"}, {126'b0, get_done(sel8), get_busy(sel8)}, 128'd0);
      chk({tag, " product_hold_idle"}, prod(sel8), exp);
    end
  endtask

  initial begin
    int done_seen;
    logic [63:0] ra, rb;
    vectors     = 0;
    miscompares = 0;
    rst64 = 1'b1; rst8 = 1'b1;
    start64 = 1'b0; a64 = '0; b64 = '0;
    start8  = 1'b0; a8  = '0; b8  = '0;
    #12;
    chk("reset64 busy_done", {126'b0, done64, busy64}, 128'd0);
    chk("reset64 product", prod(1'b0), 128'd0);
    chk("reset8 busy_done", {126'b0, done8, busy8}, 128'd0);
    chk("reset8 product", prod(1'b1), 128'd0);
    @(posedge clk); #1;
    rst64 = 1'b0; rst8 = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, 64'd2, 64'd5, 0, 1'b0, "2x5");
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, "ones_x_ones");
    run_op(1'b0, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 0, 1'b0, "2^32_sq");
    run_op(1'b0, 64'd0, 64'h0000_0000_0000_FFFF, 0, 1'b0, "zero_a");
    run_op(1'b0, 64'hDEAD_BEEF_1234_5678, 64'd0, 0, 1'b0, "zero_b");
    run_op(1'b0, 64'hDEAD_BEEF_1234_5678, 64'd1, 0, 1'b0, "b_one");
    run_op(1'b0, 64'd3, 64'd7, 10, 1'b1, "3x7_ignored_starts");
    run_op(1'b0, 64'd9, 64'd9, 0, 1'b0, "9x9");

    // Asynchronous reset between edges, mid-operation.
    drive(1'b0, 1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 64'd0, 64'd0);
    repeat (30) @(posedge clk);
    #3;
    rst64 = 1'b1;
    #1;
    chk("async_reset busy_done", {126'b0, done64, busy64}, 128'd0);
    chk("async_reset product", prod(1'b0), 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst64 = 1'b0;
    done_seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done64 || busy64) done_seen++;
    end
    chk("after_reset no_done", 128'(done_seen), 128'd0);
    run_op(1'b0, 64'd6, 64'd7, 0, 1'b0, "6x7_after_reset");

    for (int i = 0; i < 5; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run_op(1'b0, ra, rb, 0, 1'b0, "rand64");
    end

    run_op(1'b1, 64'h02, 64'h05, 0, 1'b0, "n8_2x5");
    run_op(1'b1, 64'hFF, 64'hFF, 0, 1'b0, "n8_ff_x_ff");
    run_op(1'b1, 64'h5A, 64'h01, 0, 1'b0, "n8_b_one");
    run_op(1'b1, 64'h37, 64'h11, 3, 1'b1, "n8_ignored_starts");
    for (int i = 0; i < 8; i++) begin
      ra = 64'($urandom_range(0, 255));
      rb = 64'($urandom_range(0, 255));
      run_op(1'b1, ra, rb, 0, 1'b0, "rand8");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
